rbm_layer_sequencer: RTL and testbench
======================================

// Module: rbm_layer_sequencer
// PURPOSE
//  Control FSM for the RBM datapath inside Main. Time-multiplexes the shared adder groups over the
//  hidden layer (fan-in INPUT_DIM) and then the classifier layer (fan-in HIDDEN_DIM).
//  Drives accumulate, sigmoid-sample and write-back strobes per neuron group.
//  Repeats both layers ITERATION_NUM times, then raises finish.
// PARAMETERS
//  INPUT_DIM          4  visible-layer width (hidden-layer fan-in)
//  HIDDEN_DIM         3  hidden neurons (classifier fan-in)
//  OUTPUT_DIM         2  classifier neurons
//  H_ADDER_GROUP_NUM  1  hidden neurons computed in parallel per group
//  C_ADDER_GROUP_NUM  1  classifier neurons computed in parallel per group
//  ITERATION_NUM      1  full hidden+classifier passes per input, >=1
//  SAMPLE_LATENCY     2  cycles from sample_en to a valid sigmoid/sample result, >=1
// PORTS
//  clock       in   1     single clock, rising edge
//  reset       in   1     synchronous, active-high
//  data_valid  in   1     input vector present; level, held until finish is seen
//  load_en     out  1     one-cycle strobe: latch input vector into datapath
//  layer_sel   out  1     0 = hidden layer, 1 = classifier layer
//  group_idx   out  GW    current neuron group; GW = clog2(max group count), min 1
//  in_idx      out  IW    current fan-in index; IW = clog2(max(INPUT_DIM,HIDDEN_DIM)), min 1
//  grp_mask    out  MW    valid lanes of current group; MW = max(H_/C_ADDER_GROUP_NUM)
//  acc_clear   out  1     accumulator loads (bias + product) instead of adding; with in_idx==0
//  acc_en      out  1     accumulate product at in_idx
//  sample_en   out  1     start sigmoid/stochastic sample of current group
//  result_we   out  1     write sampled group results to the layer register
//  iter_idx    out  TW    current iteration; TW = clog2(ITERATION_NUM), min 1
//  busy        out  1     high in every state except IDLE and DONE
//  finish      out  1     high while in DONE
// BEHAVIOUR
//  Reset: state=IDLE; every output 0, including indices and grp_mask. Applies next edge, even mid-run.
//  Outputs are Moore-decoded from the registered state and counters. No input-to-output comb path,
//   except the stall gating described under CONFIGURATION.
//  Group counts: HG = ceil(HIDDEN_DIM/H_ADDER_GROUP_NUM), CG = ceil(OUTPUT_DIM/C_ADDER_GROUP_NUM).
//  IDLE: data_valid=1 -> LOAD.
//  LOAD: load_en=1 for 1 cycle -> H_ACC with group=0, k=0, iter=0.
//  H_ACC: acc_en=1 and in_idx=k for k = 0..INPUT_DIM-1, one cycle each; acc_clear=1 only at k=0.
//   After k = INPUT_DIM-1 -> H_SMP.
//  H_SMP: SAMPLE_LATENCY cycles. sample_en=1 on the first cycle; result_we=1 on the last cycle.
//   Then the next group goes to H_ACC, or after group HG-1 -> C_ACC with group=0.
//  C_ACC / C_SMP: same as H_ACC / H_SMP with fan-in HIDDEN_DIM, CG groups and layer_sel=1.
//   After the last C_SMP: if iter < ITERATION_NUM-1, increment iter -> H_ACC (group 0, no reload);
//   otherwise -> DONE.
//  DONE: finish=1; leave to IDLE when data_valid=0. Back-to-back vectors require one data_valid-low cycle.
//  grp_mask: bit j = 1 iff group*GROUP_NUM + j < layer dim. The last partial group is masked.
//   Bits at or above the active layer's GROUP_NUM are 0.
//  data_valid changes while busy are ignored. A run never aborts except by reset.
//  Latency at defaults: data_valid sampled at edge E0.
//   LOAD, then 3 x (4+2) hidden cycles, then 2 x (3+2) classifier cycles; finish rises after edge E0+29.
//  General latency: 1 + ITERATION_NUM * (HG*(INPUT_DIM+SAMPLE_LATENCY) + CG*(HIDDEN_DIM+SAMPLE_LATENCY)).
// CONFIGURATION
//  SEQ_STALL_EN defined:
//   - Adds input port stall (1 bit, after data_valid).
//   - While stall=1: state, counters and indices hold.
//   - While stall=1: load_en, acc_clear, acc_en, sample_en and result_we are forced 0 combinationally.
//   - busy and finish are unaffected.
//   - Stall in IDLE or DONE has no effect on transitions.
//  SEQ_STALL_EN undefined: no stall port; the sequencer never pauses.
// TESTING
//  1 Defaults; reset, data_valid=1 -> exactly 1 load_en, 12 acc_en with layer_sel=0, 6 with layer_sel=1;
//    finish rises after edge E0+29.
//  2 HIDDEN_DIM=3, H_ADDER_GROUP_NUM=2 -> HG=2; hidden grp_mask 2'b11 then 2'b01;
//    acc_clear only when in_idx==0.
//  3 ITERATION_NUM=3 -> load_en once; iter_idx 0,1,2; finish after edge E0+1+3*28 = E0+85.
//  4 Reset asserted during C_ACC -> next edge: all outputs 0 and IDLE;
//    a new data_valid gives a full-length run again.
//  5 data_valid held high through DONE -> finish stays 1 and no restart;
//    drop for 1 cycle, raise again -> second run identical to the first.
//  6 SEQ_STALL_EN, stall=1 for 5 cycles mid H_ACC -> strobes 0 and in_idx frozen;
//    finish delayed by exactly 5 cycles.

Source files
------------

// File: rtl/rbm_layer_sequencer_if.sv
// Control/strobe bundle between the RBM layer sequencer and the datapath it drives.
// The stall input exists only when SEQ_STALL_EN is defined.
interface rbm_layer_sequencer_if #(
   parameter int unsigned GW = 2,
   parameter int unsigned IW = 2,
   parameter int unsigned MW = 1,
   parameter int unsigned TW = 1
);
   logic          data_valid;
`ifdef SEQ_STALL_EN
   logic          stall;
`endif
   logic          load_en;
   logic          layer_sel;
   logic [GW-1:0] group_idx;
   logic [IW-1:0] in_idx;
   logic [MW-1:0] grp_mask;
   logic          acc_clear;
   logic          acc_en;
   logic          sample_en;
   logic          result_we;
   logic [TW-1:0] iter_idx;
   logic          busy;
   logic          finish;

   modport master (
`ifdef SEQ_STALL_EN
      output stall,
`endif
      output data_valid,
      input  load_en, layer_sel, group_idx, in_idx, grp_mask, acc_clear,
      input  acc_en, sample_en, result_we, iter_idx, busy, finish
   );

   modport slave (
`ifdef SEQ_STALL_EN
      input  stall,
`endif
      input  data_valid,
      output load_en, layer_sel, group_idx, in_idx, grp_mask, acc_clear,
      output acc_en, sample_en, result_we, iter_idx, busy, finish
   );
endinterface

// File: rtl/rbm_layer_sequencer.sv
// Sequencer that time-multiplexes the shared adder groups over the hidden and classifier layers.
// Optional SEQ_STALL_EN adds a stall input that freezes the sequence and masks the strobes.
module rbm_layer_sequencer #(
   parameter int unsigned INPUT_DIM         = 4,
   parameter int unsigned HIDDEN_DIM        = 3,
   parameter int unsigned OUTPUT_DIM        = 2,
   parameter int unsigned H_ADDER_GROUP_NUM = 1,
   parameter int unsigned C_ADDER_GROUP_NUM = 1,
   parameter int unsigned ITERATION_NUM     = 1,
   parameter int unsigned SAMPLE_LATENCY    = 2
) (
   input logic                  clock,
   input logic                  reset,
   rbm_layer_sequencer_if.slave bus
);
   localparam int unsigned HG    = (HIDDEN_DIM + H_ADDER_GROUP_NUM - 1) / H_ADDER_GROUP_NUM;
   localparam int unsigned CG    = (OUTPUT_DIM + C_ADDER_GROUP_NUM - 1) / C_ADDER_GROUP_NUM;
   localparam int unsigned MAX_G = (HG > CG) ? HG : CG;
   localparam int unsigned MAX_F = (INPUT_DIM > HIDDEN_DIM) ? INPUT_DIM : HIDDEN_DIM;
   localparam int unsigned GW    = (MAX_G > 1) ? $clog2(MAX_G) : 1;
   localparam int unsigned IW    = (MAX_F > 1) ? $clog2(MAX_F) : 1;
   localparam int unsigned MW    = (H_ADDER_GROUP_NUM > C_ADDER_GROUP_NUM) ?
                                   H_ADDER_GROUP_NUM : C_ADDER_GROUP_NUM;
   localparam int unsigned TW    = (ITERATION_NUM > 1) ? $clog2(ITERATION_NUM) : 1;
   localparam int unsigned SW    = (SAMPLE_LATENCY > 1) ? $clog2(SAMPLE_LATENCY) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, H_ACC, H_SMP, C_ACC, C_SMP, DONE} state_t;

   state_t        state, nxt_state;
   logic [IW-1:0] k, nxt_k;
   logic [GW-1:0] grp, nxt_grp;
   logic [TW-1:0] iter, nxt_iter;
   logic [SW-1:0] scnt, nxt_scnt;
   logic          gate, hold;
   logic          load_q, layer_q, acc_clr_q, acc_en_q, smp_q, we_q, busy_q, fin_q;
   logic [MW-1:0] mask_q;

   // Valid lanes of group g: min(group size, neurons left in the layer) low bits set.
   function automatic logic [MW-1:0] mask_of(input logic csel, input logic [GW-1:0] g);
      int unsigned gn, dim, base, lanes;
      gn    = csel ? C_ADDER_GROUP_NUM : H_ADDER_GROUP_NUM;
      dim   = csel ? OUTPUT_DIM : HIDDEN_DIM;
      base  = 32'(g) * gn;
      lanes = (base >= dim) ? 0 : (((dim - base) < gn) ? (dim - base) : gn);
      return MW'((64'(1) << lanes) - 64'(1));
   endfunction

`ifdef SEQ_STALL_EN
   assign gate = bus.stall;
`else
   assign gate = 1'b0;
`endif
   // Stall only freezes an active run; IDLE and DONE keep reacting to data_valid.
   assign hold = gate && (state != IDLE) && (state != DONE);

   always_comb begin
      nxt_state = state;
      nxt_k     = k;
      nxt_grp   = grp;
      nxt_iter  = iter;
      nxt_scnt  = scnt;
      if (!hold) begin
         case (state)
            IDLE: if (bus.data_valid) nxt_state = LOAD;
            LOAD: begin
               nxt_state = H_ACC;
               nxt_k     = '0;
               nxt_grp   = '0;
               nxt_iter  = '0;
            end
            H_ACC: begin
               if (k == IW'(INPUT_DIM - 1)) begin
                  nxt_state = H_SMP;
                  nxt_k     = '0;
                  nxt_scnt  = '0;
               end else begin
                  nxt_k = k + 1'b1;
               end
            end
            H_SMP: begin
               if (scnt == SW'(SAMPLE_LATENCY - 1)) begin
                  nxt_state = (grp == GW'(HG - 1)) ? C_ACC : H_ACC;
                  nxt_grp   = (grp == GW'(HG - 1)) ? '0 : grp + 1'b1;
               end else begin
                  nxt_scnt = scnt + 1'b1;
               end
            end
            C_ACC: begin
               if (k == IW'(HIDDEN_DIM - 1)) begin
                  nxt_state = C_SMP;
                  nxt_k     = '0;
                  nxt_scnt  = '0;
               end else begin
                  nxt_k = k + 1'b1;
               end
            end
            C_SMP: begin
               if (scnt != SW'(SAMPLE_LATENCY - 1)) begin
                  nxt_scnt = scnt + 1'b1;
               end else if (grp != GW'(CG - 1)) begin
                  nxt_state = C_ACC;
                  nxt_grp   = grp + 1'b1;
               end else if (iter != TW'(ITERATION_NUM - 1)) begin
                  // Next pass reuses the latched input vector.
                  nxt_state = H_ACC;
                  nxt_grp   = '0;
                  nxt_iter  = iter + 1'b1;
               end else begin
                  nxt_state = DONE;
                  nxt_grp   = '0;
               end
            end
            DONE: begin
               if (!bus.data_valid) begin
                  nxt_state = IDLE;
                  nxt_iter  = '0;
               end
            end
            default: nxt_state = IDLE;
         endcase
      end
   end

   // State, counters and Moore outputs decoded one cycle ahead from the next state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         k         <= '0;
         grp       <= '0;
         iter      <= '0;
         scnt      <= '0;
         load_q    <= 1'b0;
         layer_q   <= 1'b0;
         acc_clr_q <= 1'b0;
         acc_en_q  <= 1'b0;
         smp_q     <= 1'b0;
         we_q      <= 1'b0;
         busy_q    <= 1'b0;
         fin_q     <= 1'b0;
         mask_q    <= '0;
      end else begin
         state     <= nxt_state;
         k         <= nxt_k;
         grp       <= nxt_grp;
         iter      <= nxt_iter;
         scnt      <= nxt_scnt;
         load_q    <= (nxt_state == LOAD);
         layer_q   <= (nxt_state == C_ACC) || (nxt_state == C_SMP);
         acc_en_q  <= (nxt_state == H_ACC) || (nxt_state == C_ACC);
         acc_clr_q <= ((nxt_state == H_ACC) || (nxt_state == C_ACC)) && (nxt_k == '0);
         smp_q     <= ((nxt_state == H_SMP) || (nxt_state == C_SMP)) && (nxt_scnt == '0);
         we_q      <= ((nxt_state == H_SMP) || (nxt_state == C_SMP)) &&
                      (nxt_scnt == SW'(SAMPLE_LATENCY - 1));
         busy_q    <= (nxt_state != IDLE) && (nxt_state != DONE);
         fin_q     <= (nxt_state == DONE);
         if ((nxt_state == H_ACC) || (nxt_state == H_SMP))
            mask_q <= mask_of(1'b0, nxt_grp);
         else if ((nxt_state == C_ACC) || (nxt_state == C_SMP))
            mask_q <= mask_of(1'b1, nxt_grp);
         else
            mask_q <= '0;
      end
   end

   assign bus.load_en   = load_q    & ~gate;
   assign bus.acc_clear = acc_clr_q & ~gate;
   assign bus.acc_en    = acc_en_q  & ~gate;
   assign bus.sample_en = smp_q     & ~gate;
   assign bus.result_we = we_q      & ~gate;
   assign bus.layer_sel = layer_q;
   assign bus.group_idx = grp;
   assign bus.in_idx    = k;
   assign bus.grp_mask  = mask_q;
   assign bus.iter_idx  = iter;
   assign bus.busy      = busy_q;
   assign bus.finish    = fin_q;
endmodule

// File: tb/tb_rbm_layer_sequencer.sv
// Directed bench for rbm_layer_sequencer: defaults, 2-lane hidden groups and 3 iterations.
// Exercises the stall path when SEQ_STALL_EN is defined.
module tb_rbm_layer_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int unsigned total = 0;
   int unsigned bad   = 0;
   logic        mon_clr = 1'b0;

   rbm_layer_sequencer_if #(.GW(2), .IW(2), .MW(1), .TW(1)) if0 ();
   rbm_layer_sequencer_if #(.GW(1), .IW(2), .MW(2), .TW(1)) if1 ();
   rbm_layer_sequencer_if #(.GW(2), .IW(2), .MW(1), .TW(2)) if2 ();

   rbm_layer_sequencer u0 (.clock(clk), .reset(rst), .bus(if0.slave));
   rbm_layer_sequencer #(.H_ADDER_GROUP_NUM(2)) u1 (.clock(clk), .reset(rst), .bus(if1.slave));
   rbm_layer_sequencer #(.ITERATION_NUM(3))     u2 (.clock(clk), .reset(rst), .bus(if2.slave));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Per-run strobe counters, cleared at the start of each run.
   int unsigned ld0, acch0, accc0, clr0, smp0, we0, busy0;
   int unsigned m11g0, m01g1, cmask1, clr1, clrbad1;
   int unsigned ld2;
   int unsigned it_acc [4];

   always @(negedge clk) begin
      if (mon_clr) begin
         ld0 = 0; acch0 = 0; accc0 = 0; clr0 = 0; smp0 = 0; we0 = 0; busy0 = 0;
         m11g0 = 0; m01g1 = 0; cmask1 = 0; clr1 = 0; clrbad1 = 0; ld2 = 0;
         for (int i = 0; i < 4; i++) it_acc[i] = 0;
      end else begin
         if (if0.load_en) ld0++;
         if (if0.acc_en && !if0.layer_sel) acch0++;
         if (if0.acc_en && if0.layer_sel) accc0++;
         if (if0.acc_clear) clr0++;
         if (if0.sample_en) smp0++;
         if (if0.result_we) we0++;
         if (if0.busy) busy0++;
         if (if1.acc_en && !if1.layer_sel && if1.group_idx == 1'b0 && if1.grp_mask == 2'b11) m11g0++;
         if (if1.acc_en && !if1.layer_sel && if1.group_idx == 1'b1 && if1.grp_mask == 2'b01) m01g1++;
         if (if1.acc_en && if1.layer_sel && if1.grp_mask == 2'b01) cmask1++;
         if (if1.acc_clear) clr1++;
         if (if1.acc_clear && if1.in_idx != 2'd0) clrbad1++;
         if (if2.load_en) ld2++;
         if (if2.acc_en) it_acc[if2.iter_idx]++;
      end
   end

   task automatic set_dv(input int sel, input logic v);
      case (sel)
         0:       if0.data_valid = v;
         1:       if1.data_valid = v;
         default: if2.data_valid = v;
      endcase
   endtask

   function automatic logic fin(input int sel);
      case (sel)
         0:       return if0.finish;
         1:       return if1.finish;
         default: return if2.finish;
      endcase
   endfunction

   // One low cycle on data_valid, then raise it; n = edges after E0 until finish is seen.
   task automatic run_vec(input int sel, output int unsigned n);
      mon_clr = 1'b1;
      @(negedge clk);
      #1 mon_clr = 1'b0;
      set_dv(sel, 1'b0);
      @(negedge clk);
      set_dv(sel, 1'b1);
      @(posedge clk);
      #1 n = 0;
      while (!fin(sel) && n < 300) begin
         @(posedge clk);
         #1 n++;
      end
   endtask

   function automatic logic [31:0] outs0();
      return 32'({if0.load_en, if0.layer_sel, if0.group_idx, if0.in_idx, if0.grp_mask,
                  if0.acc_clear, if0.acc_en, if0.sample_en, if0.result_we, if0.iter_idx,
                  if0.busy, if0.finish});
   endfunction

   initial begin
      int unsigned n;
      if0.data_valid = 1'b0;
      if1.data_valid = 1'b0;
      if2.data_valid = 1'b0;
`ifdef SEQ_STALL_EN
      if0.stall = 1'b0;
      if1.stall = 1'b0;
      if2.stall = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outs_u0", outs0(), 0);
      chk("rst_mask_u1", 32'(if1.grp_mask), 0);
      chk("rst_busy_u2", 32'({if2.busy, if2.iter_idx, if2.finish}), 0);
      @(negedge clk) rst = 1'b0;

      // Default run
      run_vec(0, n);
      chk("def_latency", n, 29);
      chk("def_load", ld0, 1);
      chk("def_acc_hidden", acch0, 12);
      chk("def_acc_class", accc0, 6);
      chk("def_clear", clr0, 5);
      chk("def_sample", smp0, 5);
      chk("def_we", we0, 5);
      chk("def_busy", busy0, 29);

      // data_valid held high through DONE: no restart
      repeat (10) @(posedge clk);
      #1;
      chk("hold_finish", 32'(if0.finish), 1);
      chk("hold_busy", 32'(if0.busy), 0);
      chk("hold_no_reload", ld0, 1);
      chk("hold_busy_cnt", busy0, 29);
      run_vec(0, n);
      chk("rerun_latency", n, 29);
      chk("rerun_acc_hidden", acch0, 12);
      chk("rerun_acc_class", accc0, 6);

      // Two-lane hidden groups, last group partial
      run_vec(1, n);
      chk("grp2_latency", n, 23);
      chk("grp2_mask11_g0", m11g0, 4);
      chk("grp2_mask01_g1", m01g1, 4);
      chk("grp2_class_mask", cmask1, 6);
      chk("grp2_clear", clr1, 4);
      chk("grp2_clear_k0", clrbad1, 0);

      // Three iterations, single load
      run_vec(2, n);
      chk("iter3_latency", n, 85);
      chk("iter3_load", ld2, 1);
      chk("iter3_acc_i0", it_acc[0], 18);
      chk("iter3_acc_i1", it_acc[1], 18);
      chk("iter3_acc_i2", it_acc[2], 18);
      chk("iter3_acc_i3", it_acc[3], 0);

      // Reset during C_ACC
      @(negedge clk) if0.data_valid = 1'b0;
      @(negedge clk) if0.data_valid = 1'b1;
      for (int i = 0; i < 100 && !(if0.acc_en && if0.layer_sel); i++) @(negedge clk);
      chk("abort_in_cacc", 32'({if0.acc_en, if0.layer_sel}), 3);
      #2 rst = 1'b1;
      if0.data_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_outs", outs0(), 0);
      @(negedge clk) rst = 1'b0;
      run_vec(0, n);
      chk("abort_rerun_latency", n, 29);
      chk("abort_rerun_class", accc0, 6);

`ifdef SEQ_STALL_EN
      // Five stall cycles in the middle of H_ACC
      fork
         run_vec(0, n);
         begin
            for (int i = 0; i < 100 && !(if0.acc_en && !if0.layer_sel && if0.in_idx == 2'd1); i++)
               @(negedge clk);
            #2 if0.stall = 1'b1;
            #1;
            chk("stall_acc_en", 32'(if0.acc_en), 0);
            chk("stall_clear", 32'(if0.acc_clear), 0);
            chk("stall_busy", 32'(if0.busy), 1);
            repeat (4) begin
               @(negedge clk);
               chk("stall_in_idx", 32'(if0.in_idx), 1);
            end
            @(negedge clk);
            #2 if0.stall = 1'b0;
         end
      join
      chk("stall_latency", n, 34);
      chk("stall_acc_hidden", acch0, 12);
      chk("stall_load", ld0, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
